snake_body_engine: RTL

//  Parametrised snake body store and draw sequencer, the successor to the fixed two-segment mover.

---
 rtl/snake_body_engine_pkg.sv | 32 +++
 rtl/snake_body_engine_square_raster.sv | 67 ++++++
 rtl/snake_body_engine.sv | 271 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/snake_body_engine_pkg.sv
// Shared encodings for the snake body engine: directions, FSM states, screen geometry.
package snake_body_engine_pkg;

    localparam int XW = 8;
    localparam int YW = 7;

    localparam int SCREEN_W = 160;
    localparam int SCREEN_H = 120;

    typedef enum logic [1:0] {
        DIR_RIGHT = 2'd0,
        DIR_DOWN  = 2'd1,
        DIR_UP    = 2'd2,
        DIR_LEFT  = 2'd3
    } dir_e;

    typedef enum logic [2:0] {
        ST_INIT  = 3'd0,
        ST_IDLE  = 3'd1,
        ST_CHECK = 3'd2,
        ST_ERASE = 3'd3,
        ST_SHIFT = 3'd4,
        ST_DRAW  = 3'd5,
        ST_DEAD  = 3'd6
    } state_e;

    // Opposite direction; the encoding makes this a simple bit flip.
    function automatic dir_e reverse_of(input dir_e d);
        return dir_e'(d ^ 2'b11);
    endfunction

endpackage

// File: rtl/snake_body_engine_square_raster.sv
// SEG x SEG raster scan shared by the init, erase and draw phases.
// A start pulse makes (0,0) current on the following cycle; xc runs fastest.
// done marks the last pixel; a start in the same cycle chains the next square.
module snake_body_engine_square_raster #(
    parameter int SEG = 10,
    parameter int CW  = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    output logic          active,
    output logic          done,
    output logic [CW-1:0] xc,
    output logic [CW-1:0] yc
);

    localparam logic [CW-1:0] LAST = CW'(SEG - 1);

    logic          run_q, run_d;
    logic [CW-1:0] xc_q, xc_d;
    logic [CW-1:0] yc_q, yc_d;
    logic          last;

    // Next scan position: restart on start, otherwise advance while running.
    always_comb begin
        run_d = run_q;
        xc_d  = xc_q;
        yc_d  = yc_q;
        last  = (xc_q == LAST) && (yc_q == LAST);
        if (start) begin
            run_d = 1'b1;
            xc_d  = '0;
            yc_d  = '0;
        end else if (run_q) begin
            if (xc_q == LAST) begin
                xc_d = '0;
                if (last) begin
                    yc_d  = '0;
                    run_d = 1'b0;
                end else begin
                    yc_d = yc_q + 1'b1;
                end
            end else begin
                xc_d = xc_q + 1'b1;
            end
        end
    end

    // Scan counter registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            run_q <= 1'b0;
            xc_q  <= '0;
            yc_q  <= '0;
        end else begin
            run_q <= run_d;
            xc_q  <= xc_d;
            yc_q  <= yc_d;
        end
    end

    assign active = run_q;
    assign done   = run_q && last;
    assign xc     = xc_q;
    assign yc     = yc_q;

endmodule

// File: rtl/snake_body_engine.sv
// Snake body store and move/collision/draw sequencer streaming pixels to a vga_adapter.
//
//  state | meaning
//  INIT  | draw segments length-1 down to 0 after reset
//  IDLE  | wait for step; compute new head, catch wall hits
//  CHECK | compare new head against each body segment
//  ERASE | paint the vacating tail square with background
//  SHIFT | move all segments down one slot, insert new head
//  DRAW  | paint the new head square
//  DEAD  | collision seen; everything frozen until Reset
module snake_body_engine
    import snake_body_engine_pkg::*;
#(
    parameter int MAX_LEN  = 16,
    parameter int INIT_LEN = 2,
    parameter int SEG      = 10,
    parameter int XSCREEN  = SCREEN_W,
    parameter int YSCREEN  = SCREEN_H,
    parameter int X0       = 39,
    parameter int Y0       = 59,
    parameter bit WRAP     = 1'b0,
    parameter int LW       = 5
) (
    input  logic          CLOCK_50,
    input  logic          Reset,
    input  logic          step,
    input  logic [1:0]    dir_in,
    input  logic          grow,
    output logic [XW-1:0] VGA_X,
    output logic [YW-1:0] VGA_Y,
    output logic          plot,
    output logic          erase,
    output logic          busy,
    output logic          collide,
    output logic [LW-1:0] length
);

    localparam int IW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam int CW = $clog2(SEG + 1);
    localparam int XS = XW + 1;
    localparam int YS = YW + 1;

    localparam logic [LW-1:0]        MAX_LEN_L  = LW'(MAX_LEN);
    localparam logic [LW-1:0]        INIT_LEN_L = LW'(INIT_LEN);
    localparam logic [IW-1:0]        INIT_IDX   = IW'(INIT_LEN - 1);
    localparam logic signed [XS-1:0] STEP_X     = XS'(SEG);
    localparam logic signed [YS-1:0] STEP_Y     = YS'(SEG);
    localparam logic signed [XS-1:0] X_MAX      = XS'(XSCREEN - SEG);
    localparam logic signed [YS-1:0] Y_MAX      = YS'(YSCREEN - SEG);

    state_e               state_q, state_d;
    dir_e                 dir_q, dir_d, dsel;
    logic                 grow_q, grow_d;
    logic [XW-1:0]        nx_q, nx_d, cand_x, ox;
    logic [YW-1:0]        ny_q, ny_d, cand_y, oy;
    logic [LW-1:0]        len_q, len_d;
    logic [IW-1:0]        idx_q, idx_d, tail_idx;
    logic                 collide_q, collide_d;
    logic [XW-1:0]        seg_x_q [MAX_LEN];
    logic [XW-1:0]        seg_x_d [MAX_LEN];
    logic [YW-1:0]        seg_y_q [MAX_LEN];
    logic [YW-1:0]        seg_y_d [MAX_LEN];
    logic [XW-1:0]        vga_x_q, vga_x_d;
    logic [YW-1:0]        vga_y_q, vga_y_d;
    logic                 plot_q, plot_d;
    logic                 erase_q, erase_d;
    logic signed [XS-1:0] hx;
    logic signed [YS-1:0] hy;
    logic                 wall, hit;
    logic                 rs_start, rs_active, rs_done;
    logic [CW-1:0]        rs_xc, rs_yc;

    snake_body_engine_square_raster #(
        .SEG (SEG),
        .CW  (CW)
    ) u_raster (
        .clk    (CLOCK_50),
        .rst    (Reset),
        .start  (rs_start),
        .active (rs_active),
        .done   (rs_done),
        .xc     (rs_xc),
        .yc     (rs_yc)
    );

    // Candidate head for a step request: one grid step from the head, widened so edges show up as sign or overflow.
    always_comb begin
        dsel = (dir_e'(dir_in) == reverse_of(dir_q)) ? dir_q : dir_e'(dir_in);
        hx   = $signed({1'b0, seg_x_q[0]});
        hy   = $signed({1'b0, seg_y_q[0]});
        case (dsel)
            DIR_RIGHT: hx = hx + STEP_X;
            DIR_DOWN:  hy = hy + STEP_Y;
            DIR_UP:    hy = hy - STEP_Y;
            default:   hx = hx - STEP_X;
        endcase
        wall = hx[XS-1] || (hx > X_MAX) || hy[YS-1] || (hy > Y_MAX);
        if (hx[XS-1]) begin
            cand_x = X_MAX[XW-1:0];
        end else if (hx > X_MAX) begin
            cand_x = '0;
        end else begin
            cand_x = hx[XW-1:0];
        end
        if (hy[YS-1]) begin
            cand_y = Y_MAX[YW-1:0];
        end else if (hy > Y_MAX) begin
            cand_y = '0;
        end else begin
            cand_y = hy[YW-1:0];
        end
    end

    // Sequencer next state, segment shifting and raster starts.
    always_comb begin
        state_d   = state_q;
        dir_d     = dir_q;
        grow_d    = grow_q;
        nx_d      = nx_q;
        ny_d      = ny_q;
        len_d     = len_q;
        idx_d     = idx_q;
        collide_d = collide_q;
        seg_x_d   = seg_x_q;
        seg_y_d   = seg_y_q;
        rs_start  = 1'b0;
        tail_idx  = IW'(len_q - 1'b1);
        // The tail slot is free to enter unless the snake is growing and keeps it.
        hit = (seg_x_q[idx_q] == nx_q) && (seg_y_q[idx_q] == ny_q) &&
              ((idx_q != tail_idx) || grow_q);
        case (state_q)
            ST_INIT: begin
                if (!rs_active) begin
                    rs_start = 1'b1;
                end else if (rs_done) begin
                    if (idx_q == '0) begin
                        state_d = ST_IDLE;
                    end else begin
                        idx_d    = idx_q - 1'b1;
                        rs_start = 1'b1;
                    end
                end
            end
            ST_IDLE: begin
                if (step) begin
                    dir_d = dsel;
                    if (wall && !WRAP) begin
                        collide_d = 1'b1;
                        state_d   = ST_DEAD;
                    end else begin
                        nx_d    = cand_x;
                        ny_d    = cand_y;
                        grow_d  = grow && (len_q < MAX_LEN_L);
                        idx_d   = '0;
                        state_d = ST_CHECK;
                    end
                end
            end
            ST_CHECK: begin
                if (hit) begin
                    collide_d = 1'b1;
                    state_d   = ST_DEAD;
                end else if (idx_q == tail_idx) begin
                    if (grow_q) begin
                        state_d = ST_SHIFT;
                    end else begin
                        state_d  = ST_ERASE;
                        rs_start = 1'b1;
                    end
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            ST_ERASE: begin
                if (rs_done) begin
                    state_d = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                for (int i = 1; i < MAX_LEN; i++) begin
                    seg_x_d[i] = seg_x_q[i-1];
                    seg_y_d[i] = seg_y_q[i-1];
                end
                seg_x_d[0] = nx_q;
                seg_y_d[0] = ny_q;
                if (grow_q) begin
                    len_d = len_q + 1'b1;
                end
                state_d  = ST_DRAW;
                rs_start = 1'b1;
            end
            ST_DRAW: begin
                if (rs_done) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_DEAD;
            end
        endcase
    end

    // Pixel address: square origin for the current phase plus raster offset.
    always_comb begin
        case (state_q)
            ST_INIT: begin
                ox = seg_x_q[idx_q];
                oy = seg_y_q[idx_q];
            end
            ST_ERASE: begin
                ox = seg_x_q[tail_idx];
                oy = seg_y_q[tail_idx];
            end
            default: begin
                ox = seg_x_q[0];
                oy = seg_y_q[0];
            end
        endcase
        vga_x_d = rs_active ? (ox + XW'(rs_xc)) : vga_x_q;
        vga_y_d = rs_active ? (oy + YW'(rs_yc)) : vga_y_q;
        plot_d  = rs_active;
        erase_d = rs_active && (state_q == ST_ERASE);
    end

    // State, segment store and registered pixel outputs.
    always_ff @(posedge CLOCK_50 or posedge Reset) begin
        if (Reset) begin
            state_q   <= ST_INIT;
            dir_q     <= DIR_RIGHT;
            grow_q    <= 1'b0;
            nx_q      <= '0;
            ny_q      <= '0;
            len_q     <= INIT_LEN_L;
            idx_q     <= INIT_IDX;
            collide_q <= 1'b0;
            vga_x_q   <= '0;
            vga_y_q   <= '0;
            plot_q    <= 1'b0;
            erase_q   <= 1'b0;
            for (int i = 0; i < MAX_LEN; i++) begin
                seg_x_q[i] <= XW'(X0 - i * SEG);
                seg_y_q[i] <= YW'(Y0);
            end
        end else begin
            state_q   <= state_d;
            dir_q     <= dir_d;
            grow_q    <= grow_d;
            nx_q      <= nx_d;
            ny_q      <= ny_d;
            len_q     <= len_d;
            idx_q     <= idx_d;
            collide_q <= collide_d;
            vga_x_q   <= vga_x_d;
            vga_y_q   <= vga_y_d;
            plot_q    <= plot_d;
            erase_q   <= erase_d;
            seg_x_q   <= seg_x_d;
            seg_y_q   <= seg_y_d;
        end
    end

    // busy stays up until the last registered pixel has left.
    assign busy    = ((state_q != ST_IDLE) && (state_q != ST_DEAD)) || plot_q;
    assign VGA_X   = vga_x_q;
    assign VGA_Y   = vga_y_q;
    assign plot    = plot_q;
    assign erase   = erase_q;
    assign collide = collide_q;
    assign length  = len_q;

endmodule
